// File: rtl/bp_capture_ctrl_pkg.sv
// Shared types and constants for the backplane capture controller.
// Holds the FSM state encoding (readable over the debug port) and the IDLE_CYCLES legality check.
package bp_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int IDLE_CNT_W = 8;

    // The idle counter saturates at 255, so a threshold above 254 could never be exceeded.
    function automatic bit idle_cycles_legal(input int n);
        return (n >= 1) && (n <= 254);
    endfunction

endpackage

// File: rtl/bp_capture_ctrl_if.sv
// Buffer write port: valid/ready handshake carrying one packed word and its address.
interface bp_capture_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/bp_capture_ctrl_idle_detect.sv
// Backplane front end: synchronisers, registered rise/fall pulses with aligned data bit,
// and a saturating counter of consecutive high cycles used to spot inter-frame gaps.
module bp_idle_detect
    import bp_capture_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_bp_clk,
    input  logic i_bp_data,
    output logic o_rise,
    output logic o_fall,
    output logic o_bit,
    output logic o_idle
);
    localparam logic [IDLE_CNT_W-1:0] LP_IDLE_THR = IDLE_CNT_W'(IDLE_CYCLES);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_bit;
    logic [IDLE_CNT_W-1:0]  r_cnt;
    logic                   w_clk_s;
    logic                   w_data_s;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= '0;
            r_data_sync <= '0;
            r_clk_d     <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_bit       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_bp_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_bp_data};
            r_clk_d     <= w_clk_s;
            // Data is registered on the same edge as the pulse so the two stay aligned.
            r_rise      <= w_clk_s & ~r_clk_d;
            r_fall      <= ~w_clk_s & r_clk_d;
            r_bit       <= w_data_s;
            if (!w_clk_s)
                r_cnt <= '0;
            else if (r_cnt != {IDLE_CNT_W{1'b1}})
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_bit  = r_bit;
    assign o_idle = (r_cnt > LP_IDLE_THR);

endmodule

// File: rtl/bp_capture_ctrl.sv
// Frame capture sequencer: waits for a backplane idle gap, packs sampled bits MSB-first
// into words and writes them to the capture buffer, reporting status to the register bank.
module bp_capture_ctrl
    import bp_capture_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 128,
    parameter int WORD_W      = 32,
    parameter int MAX_WORDS   = 256,
    parameter int SYNC_STAGES = 2,
    localparam int ADDR_W     = $clog2(MAX_WORDS),
    localparam int FW_W       = ADDR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bp_clk,
    input  logic             i_bp_data,
    input  logic             i_arm,
    input  logic             i_abort,
    bp_capture_ctrl_if.master wr,
    output logic             o_busy,
    output logic             o_done,
    output logic [FW_W-1:0]  o_frame_words,
    output logic             o_overflow,
    output logic [2:0]       o_state
);
    localparam int CNT_W = $clog2(WORD_W + 1);

    generate
        if (!idle_cycles_legal(IDLE_CYCLES)) begin : g_bad_idle
            $error("bp_capture_ctrl: IDLE_CYCLES must be within 1..254");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("bp_capture_ctrl: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic w_rise, w_fall, w_bit, w_idle, w_idle_rise;

    bp_idle_detect #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_idle (
        .clk       (clk),
        .rst       (rst),
        .i_bp_clk  (i_bp_clk),
        .i_bp_data (i_bp_data),
        .o_rise    (w_rise),
        .o_fall    (w_fall),
        .o_bit     (w_bit),
        .o_idle    (w_idle)
    );

    state_t            r_state, w_next;
    logic              r_idle_d;
    logic              w_enter_armed;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [WORD_W-1:0] r_shift;
    logic              r_flush_sent;
    logic              r_valid;
    logic [WORD_W-1:0] r_data;
    logic [FW_W-1:0]   r_fw;
    logic              r_ovf;

    logic [WORD_W-1:0] w_full_word, w_flush_word, w_word;
    logic [CNT_W-1:0]  w_shamt;
    logic              w_word_done, w_flush_req, w_req;
    logic              w_accept, w_room, w_take, w_drop;

    assign w_idle_rise = w_idle & ~r_idle_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idle_d <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_idle_d <= w_idle;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_enter_armed = 1'b0;
        if (i_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (i_arm) w_next = ST_SYNC;
                ST_SYNC: begin
                    if (w_idle) begin
                        w_next        = ST_ARMED;
                        w_enter_armed = 1'b1;
                    end
                end
                ST_ARMED:   if (w_fall) w_next = ST_CAPTURE;
                ST_CAPTURE: begin
                    if (w_idle_rise)
                        w_next = (r_bitcnt != '0) ? ST_FLUSH : ST_DONE;
                end
                // Leave only once the partial word (or an older pending word) is resolved.
                ST_FLUSH:   if (r_flush_sent && (!r_valid || wr.wr_ready)) w_next = ST_DONE;
                ST_DONE: begin
                    if (i_arm) begin
                        w_next        = ST_ARMED;
                        w_enter_armed = 1'b1;
                    end
                end
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    assign w_full_word  = {r_shift[WORD_W-2:0], w_bit};
    assign w_shamt      = CNT_W'(WORD_W) - r_bitcnt;
    // Stale bits from earlier words sit above the live ones and fall off the top here.
    assign w_flush_word = r_shift << w_shamt;
    assign w_word_done  = (r_state == ST_CAPTURE) && w_rise && (r_bitcnt == CNT_W'(WORD_W - 1));
    assign w_flush_req  = (r_state == ST_FLUSH) && !r_flush_sent;
    assign w_req        = w_word_done | w_flush_req;
    assign w_word       = w_word_done ? w_full_word : w_flush_word;

    assign w_accept = r_valid & wr.wr_ready;
    assign w_room   = ((r_fw + FW_W'(w_accept)) < FW_W'(MAX_WORDS));
    assign w_take   = w_req && w_room && !(r_valid && !wr.wr_ready);
    assign w_drop   = w_req && !w_take;

    always_ff @(posedge clk) begin
        if (w_enter_armed)
            r_shift <= '0;
        else if ((r_state == ST_CAPTURE) && w_rise)
            r_shift <= w_full_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitcnt     <= '0;
            r_flush_sent <= 1'b0;
        end else begin
            r_flush_sent <= (r_state == ST_FLUSH) && !i_abort;
            if (w_enter_armed)
                r_bitcnt <= '0;
            else if ((r_state == ST_CAPTURE) && w_rise)
                r_bitcnt <= w_word_done ? '0 : r_bitcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_fw    <= '0;
            r_ovf   <= 1'b0;
        end else if (i_abort) begin
            r_valid <= 1'b0;
        end else if (w_enter_armed) begin
            r_valid <= 1'b0;
            r_fw    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept)
                r_fw <= r_fw + 1'b1;
            if (w_take) begin
                r_valid <= 1'b1;
                r_data  <= w_word;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_drop)
                r_ovf <= 1'b1;
        end
    end

    assign wr.wr_valid   = r_valid;
    assign wr.wr_data    = r_data;
    assign wr.wr_addr    = r_fw[ADDR_W-1:0];
    assign o_frame_words = r_fw;
    assign o_overflow    = r_ovf;
    assign o_state       = r_state;
    assign o_done        = (r_state == ST_DONE);
    assign o_busy        = (r_state == ST_SYNC) || (r_state == ST_ARMED) ||
                           (r_state == ST_CAPTURE) || (r_state == ST_FLUSH);

endmodule

// File: tb/tb_bp_capture_ctrl.sv
// Bench for bp_capture_ctrl: two instances (default depth and a 4-word buffer) driven by a
// shared backplane; expected writes come from a word-chunking model and are popped on accept.
module tb_bp_capture_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic bp_clk, bp_data;
    logic arm0, abort0, arm1, abort1;
    logic busy0, done0, ovf0, busy1, done1, ovf1;
    logic [8:0] fw0;
    logic [2:0] fw1;
    logic [2:0] st0, st1;
    int rmode0, rmode1;
    int tests = 0;
    int fails = 0;

    typedef struct {int addr; logic [31:0] data;} wr_t;
    wr_t sb0[$];
    wr_t sb1[$];

    always #5 clk = ~clk;

    bp_capture_ctrl_if #(.ADDR_W(8), .WORD_W(32)) if0();
    bp_capture_ctrl_if #(.ADDR_W(2), .WORD_W(32)) if1();

    bp_capture_ctrl u0 (
        .clk(clk), .rst(rst), .i_bp_clk(bp_clk), .i_bp_data(bp_data),
        .i_arm(arm0), .i_abort(abort0), .wr(if0), .o_busy(busy0), .o_done(done0),
        .o_frame_words(fw0), .o_overflow(ovf0), .o_state(st0)
    );

    bp_capture_ctrl #(.MAX_WORDS(4)) u1 (
        .clk(clk), .rst(rst), .i_bp_clk(bp_clk), .i_bp_data(bp_data),
        .i_arm(arm1), .i_abort(abort1), .wr(if1), .o_busy(busy1), .o_done(done1),
        .o_frame_words(fw1), .o_overflow(ovf1), .o_state(st1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Buffer-side ready: 0 = stalled, 1 = always ready, 2 = random (mostly ready).
    always @(posedge clk) begin
        #1;
        if0.wr_ready = (rmode0 == 1) || (rmode0 == 2 && $urandom_range(0, 3) != 0);
        if1.wr_ready = (rmode1 == 1) || (rmode1 == 2 && $urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin : mon0
        wr_t e;
        if (!rst && if0.wr_valid && if0.wr_ready) begin
            if (sb0.size() == 0) begin
                tests++; fails++;
                $display("FAIL u0_unexpected_write: addr %0d data %h, expected no write", if0.wr_addr, if0.wr_data);
            end else begin
                e = sb0.pop_front();
                chk("u0_wr_addr", 64'(if0.wr_addr), 64'(e.addr));
                chk("u0_wr_data", 64'(if0.wr_data), 64'(e.data));
            end
        end
    end

    always @(negedge clk) begin : mon1
        wr_t e;
        if (!rst && if1.wr_valid && if1.wr_ready) begin
            if (sb1.size() == 0) begin
                tests++; fails++;
                $display("FAIL u1_unexpected_write: addr %0d data %h, expected no write", if1.wr_addr, if1.wr_data);
            end else begin
                e = sb1.pop_front();
                chk("u1_wr_addr", 64'(if1.wr_addr), 64'(e.addr));
                chk("u1_wr_data", 64'(if1.wr_data), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        bp_clk = 1'b0;
        bp_data = b;
        repeat (4) tick();
        bp_clk = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_frame(input bit bits[$]);
        foreach (bits[i]) send_bit(bits[i]);
    endtask

    task automatic gap(input int n);
        bp_clk = 1'b1;
        repeat (n) tick();
    endtask

    task automatic words_to_bits(input logic [31:0] ws[$], input int nbits, output bit bits[$]);
        logic [31:0] w;
        bits.delete();
        for (int i = 0; i < nbits; i++) begin
            w = ws[i / 32];
            bits.push_back(w[31 - (i % 32)]);
        end
    endtask

    task automatic rand_bits(input int nbits, output bit bits[$]);
        bits.delete();
        for (int i = 0; i < nbits; i++) bits.push_back(1'($urandom_range(0, 1)));
    endtask

    // Reference: split the frame into 32-bit groups, first bit in MSB, last group zero-padded;
    // only the first maxw groups reach the buffer.
    task automatic model_frame(input int sel, input bit bits[$], input int maxw,
                               output int efw, output bit eovf);
        int nw;
        wr_t e;
        nw = (bits.size() + 31) / 32;
        for (int w = 0; w < nw; w++) begin
            e.addr = w;
            e.data = 32'h0;
            for (int k = 0; k < 32; k++)
                if (w * 32 + k < bits.size()) e.data[31 - k] = bits[w * 32 + k];
            if (w < maxw) begin
                if (sel == 0) sb0.push_back(e);
                else          sb1.push_back(e);
            end
        end
        efw  = (nw < maxw) ? nw : maxw;
        eovf = (nw > maxw);
    endtask

    task automatic status0(input string tag, input int efw, input bit eovf);
        chk({tag, "_done"}, 64'(done0), 64'd1);
        chk({tag, "_frame_words"}, 64'(fw0), 64'(efw));
        chk({tag, "_overflow"}, 64'(ovf0), 64'(eovf));
    endtask

    task automatic pulse_arm0();
        arm0 = 1'b1;
        tick();
        arm0 = 1'b0;
    endtask

    task automatic pulse_abort0();
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ws[$];
        bit bits[$];
        bit bits_b[$];
        int efw, n;
        bit eovf;
        logic [31:0] w0;

        rst = 1'b1; bp_clk = 1'b1; bp_data = 1'b0;
        arm0 = 1'b0; abort0 = 1'b0; arm1 = 1'b0; abort1 = 1'b0;
        rmode0 = 2; rmode1 = 2;
        repeat (3) tick();
        chk("rst_state", 64'(st0), 64'd0);
        chk("rst_wr_valid", 64'(if0.wr_valid), 64'd0);
        chk("rst_wr_addr", 64'(if0.wr_addr), 64'd0);
        chk("rst_wr_data", 64'(if0.wr_data), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_frame_words", 64'(fw0), 64'd0);
        chk("rst_overflow", 64'(ovf0), 64'd0);
        rst = 1'b0;

        // Two full words from an idle start.
        gap(200);
        pulse_arm0();
        tick();
        chk("t1_armed_state", 64'(st0), 64'd2);
        chk("t1_busy", 64'(busy0), 64'd1);
        ws = '{32'hDEADBEEF, 32'h01234567};
        words_to_bits(ws, 64, bits);
        model_frame(0, bits, 256, efw, eovf);
        send_frame(bits);
        gap(200);
        status0("t1", efw, eovf);

        // 40-bit frame ending in a flushed partial word; re-arm from DONE skips SYNC.
        pulse_arm0();
        chk("t2_rearm_state", 64'(st0), 64'd2);
        ws = '{32'hA5A5A5A5, 32'hFF000000};
        words_to_bits(ws, 40, bits);
        model_frame(0, bits, 256, efw, eovf);
        send_frame(bits);
        gap(200);
        status0("t2", efw, eovf);

        // Buffer stalled across two word completions.
        rmode0 = 0;
        pulse_arm0();
        w0 = $urandom();
        ws = '{w0, $urandom()};
        words_to_bits(ws, 64, bits);
        send_frame(bits);
        gap(200);
        chk("t3_valid_held", 64'(if0.wr_valid), 64'd1);
        chk("t3_data_held", 64'(if0.wr_data), 64'(w0));
        chk("t3_addr_held", 64'(if0.wr_addr), 64'd0);
        chk("t3_overflow", 64'(ovf0), 64'd1);
        chk("t3_fw_stalled", 64'(fw0), 64'd0);
        chk("t3_done", 64'(done0), 64'd1);
        e_push0(0, w0);
        rmode0 = 1;
        repeat (3) tick();
        chk("t3_fw_released", 64'(fw0), 64'd1);
        chk("t3_valid_cleared", 64'(if0.wr_valid), 64'd0);
        rmode0 = 2;

        // Four-word buffer receiving a six-word frame.
        arm1 = 1'b1; tick(); arm1 = 1'b0;
        tick();
        chk("t4_armed_state", 64'(st1), 64'd2);
        ws.delete();
        for (int i = 0; i < 6; i++) ws.push_back($urandom());
        words_to_bits(ws, 192, bits);
        model_frame(1, bits, 4, efw, eovf);
        send_frame(bits);
        repeat (10) tick();
        chk("t4_not_done_before_idle", 64'(done1), 64'd0);
        gap(200);
        chk("t4_done", 64'(done1), 64'd1);
        chk("t4_frame_words", 64'(fw1), 64'(efw));
        chk("t4_overflow", 64'(ovf1), 64'(eovf));

        // Arm mid-frame: capture must wait for the gap and take only the next frame.
        pulse_abort0();
        chk("t5_abort_idle", 64'(st0), 64'd0);
        rand_bits(48, bits);
        fork
            send_frame(bits);
            begin
                repeat (100) tick();
                pulse_arm0();
                repeat (20) tick();
                chk("t5_sync_hold", 64'(st0), 64'd1);
            end
        join
        gap(200);
        chk("t5_armed_after_gap", 64'(st0), 64'd2);
        rand_bits(32, bits_b);
        model_frame(0, bits_b, 256, efw, eovf);
        send_frame(bits_b);
        gap(200);
        status0("t5", efw, eovf);

        // Abort with a word pending on the bus, then a clean re-arm.
        rmode0 = 0;
        pulse_arm0();
        rand_bits(40, bits);
        fork
            send_frame(bits);
            begin
                n = 0;
                while (!if0.wr_valid && n < 600) begin
                    tick();
                    n++;
                end
                chk("t6_valid_before_abort", 64'(if0.wr_valid), 64'd1);
                repeat (2) tick();
                pulse_abort0();
                chk("t6_valid_dropped", 64'(if0.wr_valid), 64'd0);
                chk("t6_state_idle", 64'(st0), 64'd0);
                chk("t6_busy_low", 64'(busy0), 64'd0);
                chk("t6_fw_kept", 64'(fw0), 64'd0);
            end
        join
        rmode0 = 2;
        gap(200);
        pulse_arm0();
        tick();
        chk("t6_rearm_state", 64'(st0), 64'd2);
        rand_bits(64, bits);
        model_frame(0, bits, 256, efw, eovf);
        send_frame(bits);
        gap(200);
        status0("t6", efw, eovf);

        // Random frame lengths, including very short partial-only frames.
        for (int it = 0; it < 3; it++) begin
            pulse_arm0();
            rand_bits($urandom_range(1, 100), bits);
            model_frame(0, bits, 256, efw, eovf);
            send_frame(bits);
            gap(200);
            status0("rand", efw, eovf);
        end

        chk("sb0_drained", 64'(sb0.size()), 64'd0);
        chk("sb1_drained", 64'(sb1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic e_push0(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        sb0.push_back(e);
    endtask

endmodule

// File: doc/bp_capture_ctrl.md
# bp_capture_ctrl

Sequences frame capture from the PLC backplane into the capture buffer. It synchronises the external backplane clock and data, detects inter-frame idle gaps (clock held high), and packs sampled bits into words. Each word is written to the buffer over a valid/ready port. A start/abort pair from the AXI-Lite register bank drives it, and it reports status (busy, done, word count, overflow) back to that bank.

## Interface
Parameters:
- IDLE_CYCLES, 128, consecutive clk cycles with synced bp_clk high that mark a frame gap; legal range 1..254
- WORD_W, 32, bits packed per buffer word
- MAX_WORDS, 256, buffer depth in words; power of two
- SYNC_STAGES, 2, synchroniser flops on bp_clk and bp_data; minimum 2

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- bp_clk  in  1  asynchronous backplane clock
- bp_data  in  1  asynchronous backplane data
- arm  in  1  single-cycle start pulse
- abort  in  1  single-cycle abort pulse
- wr_valid  out  1  buffer write request
- wr_ready  in  1  buffer accepts the word
- wr_addr  out  log2(MAX_WORDS)  word address, 0-based per frame
- wr_data  out  WORD_W  packed bits, first bit in MSB
- busy  out  1  high in SYNC, ARMED, CAPTURE, FLUSH
- done  out  1  high in DONE
- frame_words  out  log2(MAX_WORDS)+1  words accepted this frame
- overflow  out  1  sticky: a word was dropped this frame
- state  out  3  FSM encoding, for debug readback

## Operation
- Synchronise bp_clk and bp_data through SYNC_STAGES flops. One further register on synced bp_clk gives rise/fall pulses. Data is sampled from the synced bp_data aligned with the rise pulse.
- Idle detector: 8-bit counter increments while synced bp_clk = 1, saturates at 255, and clears to 0 on any cycle with synced bp_clk = 0. idle = (count > IDLE_CYCLES). The counter never wraps.
- FSM states and encodings:
  - IDLE = 0: outputs quiet. arm → SYNC.
  - SYNC = 1: wait for idle = 1, then → ARMED. This keeps capture from starting mid-frame.
  - ARMED = 2: wait for first fall pulse, then → CAPTURE. On entry, clear shift register, bit count, wr_addr, frame_words and overflow.
  - CAPTURE = 3: on each rise pulse, shift the bit into the register LSB. When bit count reaches WORD_W, present the word and reset bit count to 0.
    - idle rising with bit count > 0 → FLUSH.
    - idle rising with bit count = 0 → DONE.
  - FLUSH = 4: present the partial word left-aligned, with unused LSBs zero. After the write resolves, → DONE.
  - DONE = 5: done = 1. arm → ARMED directly, because the bus is known idle.
- Write handshake:
  - wr_valid, wr_data and wr_addr are held stable until wr_ready.
  - On acceptance, wr_addr and frame_words increment.
- Drop rules:
  - If a new word completes while wr_valid && !wr_ready, the new word is dropped and overflow is set. The pending word stays.
  - Once frame_words = MAX_WORDS, later words are dropped and overflow is set. Capture continues to frame end.
- abort in any state → IDLE the next cycle. wr_valid drops immediately, even if unaccepted. frame_words and overflow keep their values.
- arm while busy is ignored. If arm and abort are both high, abort wins.

## Timing
- Reset values: state = IDLE, wr_valid = 0, wr_addr = 0, wr_data = 0, busy = 0, done = 0, frame_words = 0, overflow = 0, idle counter = 0.
- Edge latency: a bp_clk transition produces its rise/fall pulse SYNC_STAGES+1 cycles later.
- wr_valid asserts 1 cycle after the rise pulse that completes a word.
- In FLUSH, wr_valid asserts 1 cycle after entry.
- idle asserts IDLE_CYCLES+1 cycles after synced bp_clk goes high. The done transition follows 1 cycle later, when no flush is needed.
- The backplane clock must give ≥ 3 clk cycles per bp_clk phase. Faster input is unsupported and gives undefined results.
- A rise pulse and idle cannot coincide, because idle requires bp_clk high for more than 1 cycle.

## Structure
- A shared package holds the state enum and the encodings above, plus the IDLE_CYCLES legality check.
- Sub-module bp_idle_detect holds the synchroniser, edge pulses and saturating idle counter. The top level holds the FSM, shifter and write port.

## Test plan
- Reset, then arm with bp_clk held high 200 cycles, then 64 bp_clk periods (bit pattern 0xDEADBEEF, 0x01234567), then high for 200 cycles → two writes: addr 0 = 0xDEADBEEF, addr 1 = 0x01234567. Then frame_words = 2, done = 1, overflow = 0.
- A frame of 40 bits, 0xA5A5A5A5 followed by 0xFF → FLUSH writes addr 1 = 0xFF000000, frame_words = 2.
- wr_ready held low through two word completions → first word stays on the bus, overflow = 1. Releasing wr_ready gives frame_words = 1.
- MAX_WORDS = 4 with a 6-word frame → addr 0..3 written, overflow = 1, frame_words = 4, done reached only after idle.
- Arm while bp_clk toggles mid-frame → stays in SYNC until an idle gap, and the first word captured is from the next frame.
- Abort during CAPTURE with wr_valid high → wr_valid = 0 and state = IDLE the next cycle, busy = 0. A re-arm then captures normally.
